// File: rtl/score_pkg.sv
// Shared types and helpers for the lane score engine.
// FSM state encoding, mode encoding and lane index width.
package score_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_e;

    localparam logic MODE_MATCH = 1'b0;
    localparam logic MODE_HIT   = 1'b1;

    // Lane index width, never narrower than one bit.
    function automatic int unsigned lane_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lane_grader.sv
// Combinational grade of one snapshot lane.
// Selects lane idx and applies the MATCH or HIT compare.
module lane_grader
    import score_pkg::*;
#(
    parameter int N_LANES = 3,
    parameter int IDX_W   = 2
) (
    input  logic [N_LANES-1:0] led_snap,
    input  logic [N_LANES-1:0] btn_snap,
    input  logic [IDX_W-1:0]   idx,
    input  logic               mode,
    output logic               hit
);

    logic led_sel;
    logic btn_sel;

    always_comb begin
        led_sel = 1'b0;
        btn_sel = 1'b0;
        for (int i = 0; i < N_LANES; i++) begin
            if (IDX_W'(i) == idx) begin
                led_sel = led_snap[i];
                btn_sel = btn_snap[i];
            end
        end
        hit = (mode == MODE_HIT) ? (led_sel & btn_sel)
                                 : (led_sel ~^ btn_sel);
    end

endmodule

// File: rtl/lane_score_engine.sv
// Round-based lane grader: snapshots led/btn on start, grades one lane
// per clock, then folds the round score into a saturating total.
module lane_score_engine
    import score_pkg::*;
#(
    parameter  int N_LANES = 3,
    parameter  int SCORE_W = 8,
    localparam int RND_W   = $clog2(N_LANES + 1),
    localparam int LANE_W  = lane_w(N_LANES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               mode,
    input  logic               clear,
    input  logic [N_LANES-1:0] led,
    input  logic [N_LANES-1:0] btn,
    output logic               busy,
    output logic               valid,
    output logic               point,
    output logic [LANE_W-1:0]  lane,
    output logic               done,
    output logic [RND_W-1:0]   round_score,
    output logic [SCORE_W-1:0] total_score
);

    localparam int SUM_W = ((SCORE_W > RND_W) ? SCORE_W : RND_W) + 1;
    localparam logic [LANE_W-1:0] LAST_IDX = LANE_W'(N_LANES - 1);
    localparam logic [SUM_W-1:0]  MAX_SUM  = SUM_W'({SCORE_W{1'b1}});

    state_e             state_q, state_d;
    logic [N_LANES-1:0] led_q, led_d;
    logic [N_LANES-1:0] btn_q, btn_d;
    logic               mode_q, mode_d;
    logic [LANE_W-1:0]  idx_q, idx_d;
    logic               valid_q, valid_d;
    logic               point_q, point_d;
    logic [LANE_W-1:0]  lane_q, lane_d;
    logic               done_q, done_d;
    logic [RND_W-1:0]   round_q, round_d;
    logic [SCORE_W-1:0] total_q, total_d;
    logic [SUM_W-1:0]   sum;
    logic               hit;

    lane_grader #(
        .N_LANES (N_LANES),
        .IDX_W   (LANE_W)
    ) u_grader (
        .led_snap (led_q),
        .btn_snap (btn_q),
        .idx      (idx_q),
        .mode     (mode_q),
        .hit      (hit)
    );

    assign sum = SUM_W'(total_q) + SUM_W'(round_q);

    always_comb begin
        state_d = state_q;
        led_d   = led_q;
        btn_d   = btn_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        valid_d = 1'b0;
        point_d = point_q;
        lane_d  = lane_q;
        done_d  = 1'b0;
        round_d = round_q;
        total_d = total_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    led_d   = led;
                    btn_d   = btn;
                    mode_d  = mode;
                    idx_d   = '0;
                    round_d = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                valid_d = 1'b1;
                lane_d  = idx_q;
                point_d = hit;
                round_d = round_q + RND_W'(hit);
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                total_d = (sum > MAX_SUM) ? {SCORE_W{1'b1}}
                                          : sum[SCORE_W-1:0];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A coincident clear discards this round's contribution.
        if (clear) begin
            total_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            led_q   <= '0;
            btn_q   <= '0;
            mode_q  <= 1'b0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            point_q <= 1'b0;
            lane_q  <= '0;
            done_q  <= 1'b0;
            round_q <= '0;
            total_q <= '0;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
            btn_q   <= btn_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            point_q <= point_d;
            lane_q  <= lane_d;
            done_q  <= done_d;
            round_q <= round_d;
            total_q <= total_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign valid       = valid_q;
    assign point       = point_q;
    assign lane        = lane_q;
    assign done        = done_q;
    assign round_score = round_q;
    assign total_score = total_q;

endmodule

// File: tb/tb_lane_score_engine.sv
// Scoreboard bench for lane_score_engine with N_LANES=3, SCORE_W=4.
module tb_lane_score_engine;

    localparam int N  = 3;
    localparam int SW = 4;
    localparam int MAXT = (1 << SW) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         mode;
    logic         clear;
    logic [N-1:0] led;
    logic [N-1:0] btn;
    logic         busy;
    logic         valid;
    logic         point;
    logic [1:0]   lane;
    logic         done;
    logic [1:0]   round_score;
    logic [SW-1:0] total_score;

    typedef struct {
        int lane;
        int point;
    } lane_exp_t;

    typedef struct {
        int rnd;
        int tot;
    } done_exp_t;

    lane_exp_t lane_sb[$];
    done_exp_t done_sb[$];
    int n_checks = 0;
    int n_fails  = 0;
    int model_total = 0;

    lane_score_engine #(
        .N_LANES (N),
        .SCORE_W (SW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mode        (mode),
        .clear       (clear),
        .led         (led),
        .btn         (btn),
        .busy        (busy),
        .valid       (valid),
        .point       (point),
        .lane        (lane),
        .done        (done),
        .round_score (round_score),
        .total_score (total_score)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (valid === 1'b1) begin
                if (lane_sb.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    lane_exp_t e;
                    e = lane_sb.pop_front();
                    chk("lane", int'(lane), e.lane);
                    chk("point", int'(point), e.point);
                    chk("done_during_valid", int'(done), 0);
                end
            end
            if (done === 1'b1) begin
                if (done_sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    done_exp_t d;
                    d = done_sb.pop_front();
                    chk("round_score", int'(round_score), d.rnd);
                    chk("total_score", int'(total_score), d.tot);
                    chk("valid_in_done", int'(valid), 0);
                    chk("busy_in_done", int'(busy), 0);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 inside the done cycle.
    task automatic run_round(input logic [N-1:0] l, input logic [N-1:0] b,
                             input logic m, input bit disturb,
                             input bit clr);
        int r;
        int t;
        lane_exp_t e;
        done_exp_t d;
        r = 0;
        for (int i = 0; i < N; i++) begin
            e.lane  = i;
            e.point = m ? int'(l[i] & b[i]) : int'(l[i] == b[i]);
            r += e.point;
            lane_sb.push_back(e);
        end
        t = model_total + r;
        if (t > MAXT) t = MAXT;
        if (clr) t = 0;
        model_total = t;
        d.rnd = r;
        d.tot = t;
        done_sb.push_back(d);
        led   = l;
        btn   = b;
        mode  = m;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        if (disturb) begin
            led   = ~l;
            btn   = ~b;
            mode  = ~m;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (2) begin
                @(posedge clk); #1;
            end
        end else begin
            repeat (3) begin
                @(posedge clk); #1;
            end
        end
        clear = clr;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        mode  = 1'b0;
        clear = 1'b0;
        led   = '0;
        btn   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_total", int'(total_score), 0);
        chk("rst_round", int'(round_score), 0);
        rst = 1'b1;
        @(posedge clk); #1;

        run_round(3'b101, 3'b101, 1'b0, 1'b0, 1'b0);
        run_round(3'b101, 3'b111, 1'b1, 1'b0, 1'b0);
        run_round(3'b101, 3'b111, 1'b0, 1'b0, 1'b0);
        run_round(3'b110, 3'b011, 1'b1, 1'b1, 1'b0);
        repeat (4) run_round(3'b111, 3'b111, 1'b0, 1'b0, 1'b0);
        run_round(3'b101, 3'b101, 1'b1, 1'b0, 1'b1);
        run_round(3'b000, 3'b000, 1'b0, 1'b0, 1'b0);

        // Abort a round while lane 1 is being graded.
        led   = 3'b111;
        btn   = 3'b111;
        mode  = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_valid", int'(valid), 0);
        chk("abort_point", int'(point), 0);
        chk("abort_lane", int'(lane), 0);
        chk("abort_round", int'(round_score), 0);
        chk("abort_total", int'(total_score), 0);
        model_total = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        run_round(3'b111, 3'b111, 1'b1, 1'b0, 1'b0);

        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("idle_clear", int'(total_score), 0);
        model_total = 0;

        for (int k = 0; k < 6; k++) begin
            run_round(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'b0);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("lane_sb_empty", lane_sb.size(), 0);
        chk("done_sb_empty", done_sb.size(), 0);
        chk("final_total", int'(total_score), model_total);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
